ram_responder: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/ram_responder_if.sv | 17 +
 rtl/ram_responder.sv | 134 +++++++++++++
 tb/tb_ram_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types. ramstate_t is the RAM status that memory_control sees.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_responder_if.sv
// RAM request/response bundle between memory_control (master) and the RAM model (slave).
// Handshake: the master holds ramREN or ramWEN, with ramaddr and ramstore, at a level until
// ramstate shows ACCESS or ERROR. ramload is meaningful only while ramstate is ACCESS for a
// read, and ramstore is sampled on the clock edge that leaves ACCESS.
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
    modport slave  (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_responder.sv
// Cycle-accurate word-addressed RAM with programmable latency that answers memory_control.
// Define RAM_STATS_EN to add saturating read/write/error counters (rd_count, wr_count, err_count).
module ram_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LAT        = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    ram_responder_if.slave      ram
`ifdef RAM_STATS_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic [15:0]         err_count
`endif
);
    import cpu_types_pkg::*;

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_C = 4'(LAT);

    if (LAT > 15) begin : g_lat_check
        $error("ram_responder: LAT=%0d does not fit the 4-bit latency counter", LAT);
    end

    logic [31:0]           mem [DEPTH];
    ramstate_t             state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  ren_q;
    logic                  wen_q;
    logic [31:0]           load_q;

    logic                  req_any;
    logic                  req_legal;
    logic                  req_same;
    logic [DEPTH_LOG2-1:0] req_idx;

    assign req_idx   = ram.ramaddr[DEPTH_LOG2+1:2];
    assign req_any   = ram.ramREN | ram.ramWEN;
    // Legal: one direction only, word aligned, and no address bits above the storage range.
    assign req_legal = (ram.ramREN ^ ram.ramWEN) && (ram.ramaddr[1:0] == 2'b00) &&
                       ((ram.ramaddr >> (DEPTH_LOG2 + 2)) == 32'd0);
    // Only meaningful alongside req_legal: the latched address is always legal itself.
    assign req_same  = (ram.ramREN == ren_q) && (ram.ramWEN == wen_q) && (req_idx == idx_q);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FREE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            load_q  <= 32'd0;
        end else begin
            load_q <= 32'd0;
            case (state_q)
                FREE: begin
                    if (req_any && req_legal) begin
                        idx_q <= req_idx;
                        ren_q <= ram.ramREN;
                        wen_q <= ram.ramWEN;
                        cnt_q <= LAT_C;
                        if (LAT_C == 4'd0) begin
                            state_q <= ACCESS;
                            if (ram.ramREN) load_q <= mem[req_idx];
                        end else begin
                            state_q <= BUSY;
                        end
                    end else if (req_any) begin
                        state_q <= ERROR;
                    end
                end
                BUSY: begin
                    if (!req_any) begin
                        state_q <= FREE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end else if (!req_legal) begin
                        state_q <= ERROR;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                    end else if (!req_same) begin
                        idx_q <= req_idx;
                        ren_q <= ram.ramREN;
                        wen_q <= ram.ramWEN;
                        cnt_q <= LAT_C;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ACCESS;
                        if (ren_q) load_q <= mem[idx_q];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
                    state_q <= FREE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
                default: state_q <= FREE;
            endcase
        end
    end

    // Storage is not reset; a reset during BUSY leaves state FREE so no write ever lands.
    always_ff @(posedge CLK) begin
        if (state_q == ACCESS && wen_q) mem[idx_q] <= ram.ramstore;
    end

    assign ram.ramload  = load_q;
    assign ram.ramstate = state_q;

`ifdef RAM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (state_q == ACCESS && ren_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (state_q == ACCESS && wen_q && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (state_q == ERROR && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_ram_responder.sv
// Directed and randomized checks of ram_responder at LAT=2, LAT=0 and LAT=4 against a
// transaction-level model: legal requests take LAT BUSY cycles then one ACCESS, illegal ones one ERROR.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic clk;
    logic nrst;
    int   vectors;
    int   misc;

    logic [31:0] mdl [3][1024];
    int          rd_n [3];
    int          wr_n [3];
    int          er_n [3];

    ram_responder_if bus_l2 ();
    ram_responder_if bus_l0 ();
    ram_responder_if bus_l4 ();

`ifdef RAM_STATS_EN
    logic [31:0] rd_c [3];
    logic [31:0] wr_c [3];
    logic [15:0] er_c [3];
    ram_responder #(.DEPTH_LOG2(10), .LAT(2)) u_l2 (.CLK(clk), .nRST(nrst), .ram(bus_l2),
        .rd_count(rd_c[0]), .wr_count(wr_c[0]), .err_count(er_c[0]));
    ram_responder #(.DEPTH_LOG2(10), .LAT(0)) u_l0 (.CLK(clk), .nRST(nrst), .ram(bus_l0),
        .rd_count(rd_c[1]), .wr_count(wr_c[1]), .err_count(er_c[1]));
    ram_responder #(.DEPTH_LOG2(10), .LAT(4)) u_l4 (.CLK(clk), .nRST(nrst), .ram(bus_l4),
        .rd_count(rd_c[2]), .wr_count(wr_c[2]), .err_count(er_c[2]));
`else
    ram_responder #(.DEPTH_LOG2(10), .LAT(2)) u_l2 (.CLK(clk), .nRST(nrst), .ram(bus_l2));
    ram_responder #(.DEPTH_LOG2(10), .LAT(0)) u_l0 (.CLK(clk), .nRST(nrst), .ram(bus_l0));
    ram_responder #(.DEPTH_LOG2(10), .LAT(4)) u_l4 (.CLK(clk), .nRST(nrst), .ram(bus_l4));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 0 : 4;
    endfunction

    function automatic bit is_legal(input logic ren, input logic wen, input logic [31:0] a);
        return (ren != wen) && (a % 4 == 0) && (a < 32'h1000);
    endfunction

    function automatic ramstate_t get_state(input int s);
        case (s)
            0:       return bus_l2.ramstate;
            1:       return bus_l0.ramstate;
            default: return bus_l4.ramstate;
        endcase
    endfunction

    function automatic logic [31:0] get_load(input int s);
        case (s)
            0:       return bus_l2.ramload;
            1:       return bus_l0.ramload;
            default: return bus_l4.ramload;
        endcase
    endfunction

    task automatic drive(input int s, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] d);
        case (s)
            0: begin bus_l2.ramREN = ren; bus_l2.ramWEN = wen; bus_l2.ramaddr = a; bus_l2.ramstore = d; end
            1: begin bus_l0.ramREN = ren; bus_l0.ramWEN = wen; bus_l0.ramaddr = a; bus_l0.ramstore = d; end
            default: begin bus_l4.ramREN = ren; bus_l4.ramWEN = wen; bus_l4.ramaddr = a; bus_l4.ramstore = d; end
        endcase
    endtask

    task automatic check(input string tag, input int s, input ramstate_t est, input logic [31:0] eld);
        ramstate_t   st;
        logic [31:0] ld;
        st = get_state(s);
        ld = get_load(s);
        vectors++;
        assert (st === est) else begin
            misc++;
            $error("FAIL %s dut%0d ramstate observed %0d expected %0d", tag, s, st, est);
        end
        vectors++;
        assert (ld === eld) else begin
            misc++;
            $error("FAIL %s dut%0d ramload observed %h expected %h", tag, s, ld, eld);
        end
    endtask

    task automatic cmp32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            misc++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One complete transaction, started at a negedge with the DUT in FREE.
    task automatic txn(input string tag, input int s, input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d);
        bit legal;
        legal = is_legal(ren, wen, a);
        drive(s, ren, wen, a, d);
        if (legal) begin
            for (int i = 0; i < lat_of(s); i++) begin
                @(negedge clk);
                check({tag, "_busy"}, s, BUSY, 32'd0);
            end
            @(negedge clk);
            check({tag, "_access"}, s, ACCESS, ren ? mdl[s][a / 4] : 32'd0);
            if (ren) rd_n[s]++; else wr_n[s]++;
        end else begin
            @(negedge clk);
            check({tag, "_error"}, s, ERROR, 32'd0);
            er_n[s]++;
        end
        drive(s, 1'b0, 1'b0, a, d);
        @(negedge clk);
        check({tag, "_free"}, s, FREE, 32'd0);
        if (legal && wen) mdl[s][a / 4] = d;
    endtask

    task automatic clear_stats_model();
        for (int s = 0; s < 3; s++) begin
            rd_n[s] = 0;
            wr_n[s] = 0;
            er_n[s] = 0;
        end
    endtask

    initial begin
        vectors = 0;
        misc    = 0;
        clear_stats_model();
        nrst = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) check("reset", s, FREE, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Write then read at LAT=2, and the LAT=0 fast path.
        txn("wr40", 0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        txn("rd40", 0, 1'b1, 1'b0, 32'h40, 32'h0);
        txn("l0_wr0", 1, 1'b0, 1'b1, 32'h0, 32'hA5A50F0F);
        txn("l0_rd0", 1, 1'b1, 1'b0, 32'h0, 32'h0);

        // Illegal requests leave memory untouched.
        txn("wr10", 0, 1'b0, 1'b1, 32'h10, 32'h0BADC0DE);
        txn("both10", 0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
        txn("misal13", 0, 1'b1, 1'b0, 32'h13, 32'h0);
        txn("oor1000", 0, 1'b1, 1'b0, 32'h1000, 32'h0);
        txn("rd10", 0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Address change in the 2nd BUSY cycle at LAT=4 restarts the full latency.
        txn("l4_wr20", 2, 1'b0, 1'b1, 32'h20, 32'h20202020);
        txn("l4_wr24", 2, 1'b0, 1'b1, 32'h24, 32'h24242424);
        drive(2, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk); check("chg_busy1", 2, BUSY, 32'd0);
        @(negedge clk); check("chg_busy2", 2, BUSY, 32'd0);
        drive(2, 1'b1, 1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("chg_restart", 2, BUSY, 32'd0);
        end
        @(negedge clk); check("chg_access", 2, ACCESS, mdl[2][32'h24 / 4]);
        rd_n[2]++;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); check("chg_free", 2, FREE, 32'd0);

        // Dropping the request mid-BUSY returns to FREE; turning it illegal gives ERROR.
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk); check("drop_busy", 0, BUSY, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk); check("drop_free", 0, FREE, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk); check("bad_busy", 0, BUSY, 32'd0);
        drive(0, 1'b1, 1'b1, 32'h40, 32'h0);
        @(negedge clk); check("bad_error", 0, ERROR, 32'd0);
        er_n[0]++;
        drive(0, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk); check("bad_free", 0, FREE, 32'd0);

        // Reset during a pending write abandons it.
        txn("wr80", 0, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D);
        drive(0, 1'b0, 1'b1, 32'h80, 32'h12345678);
        @(negedge clk); check("rst_busy", 0, BUSY, 32'd0);
        nrst = 1'b0;
        #1;
        check("rst_async", 0, FREE, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h80, 32'h0);
        @(negedge clk); check("rst_hold", 0, FREE, 32'd0);
        nrst = 1'b1;
        clear_stats_model();
        @(negedge clk);
        txn("rd80", 0, 1'b1, 1'b0, 32'h80, 32'h0);

        // Randomized traffic over a preloaded pool of words on every DUT.
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 16; w++)
                txn("preload", s, 1'b0, 1'b1, 32'h100 + 32'(w * 4), $urandom);
        for (int n = 0; n < 60; n++) begin
            int          s;
            int          kind;
            logic [31:0] a;
            s    = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            a    = 32'h100 + 32'($urandom_range(0, 15) * 4);
            case (kind)
                0, 1, 2, 3: txn("rnd_wr", s, 1'b0, 1'b1, a, $urandom);
                4, 5, 6, 7: txn("rnd_rd", s, 1'b1, 1'b0, a, 32'h0);
                8:          txn("rnd_both", s, 1'b1, 1'b1, a, $urandom);
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        txn("rnd_misal", s, 1'b1, 1'b0, a + 32'($urandom_range(1, 3)), 32'h0);
                    else
                        txn("rnd_oor", s, 1'b0, 1'b1, 32'h1000 << $urandom_range(0, 19), $urandom);
                end
            endcase
        end

`ifdef RAM_STATS_EN
        for (int s = 0; s < 3; s++) begin
            cmp32("rd_count_rnd", rd_c[s], 32'(rd_n[s]));
            cmp32("wr_count_rnd", wr_c[s], 32'(wr_n[s]));
            cmp32("err_count_rnd", 32'(er_c[s]), 32'(er_n[s]));
        end
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        clear_stats_model();
        @(negedge clk);
        txn("st_rd0", 1, 1'b1, 1'b0, 32'h100, 32'h0);
        txn("st_rd1", 1, 1'b1, 1'b0, 32'h104, 32'h0);
        txn("st_rd2", 1, 1'b1, 1'b0, 32'h108, 32'h0);
        txn("st_wr0", 1, 1'b0, 1'b1, 32'h10C, 32'h11111111);
        txn("st_wr1", 1, 1'b0, 1'b1, 32'h110, 32'h22222222);
        txn("st_err", 1, 1'b1, 1'b0, 32'h113, 32'h0);
        cmp32("rd_count_3", rd_c[1], 32'd3);
        cmp32("wr_count_2", wr_c[1], 32'd2);
        cmp32("err_count_1", 32'(er_c[1]), 32'd1);
        nrst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            cmp32("rd_count_rst", rd_c[s], 32'd0);
            cmp32("wr_count_rst", wr_c[s], 32'd0);
            cmp32("err_count_rst", 32'(er_c[s]), 32'd0);
        end
        @(negedge clk);
        nrst = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
